vec_read_seq: RTL

VEC_READ_SEQ -- requirements
Module: vec_read_seq

---
 rtl/vec_read_pkg.sv | 28 ++
 rtl/vec_read_fifo2.sv | 63 ++++++
 rtl/vec_read_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vec_read_pkg.sv
// vec_read_pkg: shared widths, state encoding and address helper for the
// vector read sequencer (vec_read_seq) and its output FIFO (vec_read_fifo2).
//
// Contents:
//   DATA_W, ADDR_W, LEN_W, STRIDE_W  - datapath widths
//   state_t, StIdle..StFinish        - sequencer state encoding
//   next_addr()                      - modulo-2^ADDR_W address step
package vec_read_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned STRIDE_W = 8;

  // Sequencer states. Plain constants keep the encoding visible to older tools.
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StIssue  = 2'd1;
  localparam state_t StDrain  = 2'd2;
  localparam state_t StFinish = 2'd3;

  // Address step; the sum is truncated to ADDR_W, so 0xFFFF + 1 wraps to 0x0000.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0]   addr,
                                                   input logic [STRIDE_W-1:0] stride);
    return addr + {{(ADDR_W - STRIDE_W){1'b0}}, stride};
  endfunction

endpackage

// File: rtl/vec_read_fifo2.sv
// vec_read_fifo2: two-entry FIFO buffering read data between the memory and
// the streaming consumer.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset, empties the FIFO
//   push       - write push_data at the tail (ignored when full unless popping)
//   push_data  - data to write
//   pop        - remove the head entry (ignored when empty)
//   head       - current head entry, meaningful only when !empty
//   full       - two entries held
//   empty      - no entries held
//
// A push and a pop in the same cycle are both honoured when full: the popped
// slot is the one the push writes into, and it becomes the new tail.
module vec_read_fifo2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vec_read_seq.sv
// vec_read_seq: issues Length reads starting at BaseAddr against a memory with
// one-cycle read latency and streams the returned words out through a
// valid/ready interface, in issue order.
//
// Ports:
//   CLK       - rising-edge clock
//   Reset     - synchronous active-high reset (also aborts a transfer)
//   Start     - begin a transfer, sampled in IDLE only
//   BaseAddr  - first word address, latched on Start
//   Length    - element count, latched on Start (0 = empty transfer)
//   Stride    - address increment, latched on Start (VEC_READ_STRIDE_EN only)
//   MemAddr   - memory read address, holds its last issued value when idle
//   MemRead   - read strobe
//   MemData   - read data, valid the cycle after MemRead
//   OutData   - streamed element (FIFO head)
//   OutValid  - OutData valid (FIFO not empty)
//   OutReady  - consumer accepts when OutValid & OutReady
//   Busy      - high in ISSUE and DRAIN
//   Done      - one-cycle pulse in FINISH
//
// Build option: define VEC_READ_STRIDE_EN to add the Stride port; otherwise the
// stride is fixed at 1.
module vec_read_seq
  import vec_read_pkg::*;
(
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic [ADDR_W-1:0]   BaseAddr,
  input  logic [LEN_W-1:0]    Length,
`ifdef VEC_READ_STRIDE_EN
  input  logic [STRIDE_W-1:0] Stride,
`endif
  output logic [ADDR_W-1:0]   MemAddr,
  output logic                MemRead,
  input  logic [DATA_W-1:0]   MemData,
  output logic [DATA_W-1:0]   OutData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                Busy,
  output logic                Done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                rd_pend_q;
  logic [STRIDE_W-1:0] stride;

  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_count;
  logic [2:0]          occupancy;
  logic                issue;
  logic                start_xfer;

  assign start_xfer = (state_q == StIdle) & Start;

`ifdef VEC_READ_STRIDE_EN
  logic [STRIDE_W-1:0] stride_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stride_q <= '0;
    end else if (start_xfer) begin
      stride_q <= Stride;
    end
  end

  assign stride = stride_q;
`else
  assign stride = STRIDE_W'(1);
`endif

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  // Buffered + in-flight words, counted after this cycle's pop. Crediting the
  // pop lets a new read go out while the consumer drains, giving one element
  // per cycle with OutReady held high, while never exceeding the two FIFO slots.
  assign fifo_pop   = OutValid & OutReady;
  assign fifo_count = {fifo_full, ~fifo_full & ~fifo_empty};
  assign occupancy  = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
  assign issue      = (state_q == StIssue) & (occupancy < 3'd2);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          addr_d  = BaseAddr;
          rem_d   = Length;
          state_d = (Length == '0) ? StFinish : StIssue;
        end
      end

      StIssue: begin
        if (issue) begin
          addr_d = next_addr(addr_q, stride);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = StDrain;
        end
      end

      StDrain: begin
        // Leave as soon as the final element is accepted, so Done follows the
        // last transfer cycle directly. With nothing in flight, a non-full
        // FIFO that pops this cycle is holding exactly that final element.
        if (!rd_pend_q && (fifo_empty || (!fifo_full && fifo_pop))) begin
          state_d = StFinish;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      mem_addr_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      // Marks MemData as valid next cycle; cleared by reset so a word
      // returning right after reset is never pushed.
      rd_pend_q <= issue;
      if (issue) mem_addr_q <= addr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  vec_read_fifo2 #(
    .Width (DATA_W)
  ) u_fifo (
    .clk       (CLK),
    .reset     (Reset),
    .push      (rd_pend_q),
    .push_data (MemData),
    .pop       (fifo_pop),
    .head      (OutData),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign MemRead  = issue;
  // Show the live address while reading; otherwise hold the last one issued.
  assign MemAddr  = issue ? addr_q : mem_addr_q;
  assign OutValid = ~fifo_empty;
  assign Busy     = (state_q == StIssue) | (state_q == StDrain);
  assign Done     = (state_q == StFinish);

endmodule
